// File: rtl/lock_ctrl_param_if.sv
// Keypad lock bus: raw keys and switch digit in, entry/status out.
// Parameters must match the lock_ctrl_param instance it is bound to.
interface lock_ctrl_param_if #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIGIT_W    = 4,
    parameter int unsigned MAX_TRIES  = 3
);
    localparam int unsigned EW = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
    localparam int unsigned FW = $clog2(MAX_TRIES + 1);

    logic [DIGIT_W-1:0] digit_in;
    logic [3:0]         key_n;
    logic               set_mode;
    logic [EW-1:0]      entry_digits;
    logic [CW-1:0]      entry_cnt;
    logic [FW-1:0]      fail_cnt;
    logic               unlocked;
    logic               alarm;
    logic               locked_out;
    logic               code_updated;

    modport master (
        output digit_in, key_n, set_mode,
        input  entry_digits, entry_cnt, fail_cnt, unlocked, alarm, locked_out, code_updated
    );

    modport slave (
        input  digit_in, key_n, set_mode,
        output entry_digits, entry_cnt, fail_cnt, unlocked, alarm, locked_out, code_updated
    );
endinterface

// File: rtl/lock_ctrl_param.sv
// Parametrised keypad lock core: key edge detect, N-digit entry, code compare, timed unlock/alarm/lockout.
// Optional code change in UNLOCKED is enabled by defining LOCK_PWD_CHANGE_EN.
module lock_ctrl_param #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned DIGIT_MAX   = 9,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int unsigned MAX_TRIES   = 3,
    parameter int unsigned UNLOCK_CYC  = 50_000_000,
    parameter int unsigned ERR_CYC     = 25_000_000,
    parameter int unsigned LOCKOUT_CYC = 500_000_000
) (
    input  logic              clk,
    input  logic              rst,
    lock_ctrl_param_if.slave  bus
);
    localparam int unsigned EW = NUM_DIGITS * DIGIT_W;
    localparam int unsigned CW = $clog2(NUM_DIGITS + 1);
    localparam int unsigned FW = $clog2(MAX_TRIES + 1);
    localparam int unsigned MAX_CYC =
        (UNLOCK_CYC > ERR_CYC) ? ((UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC)
                               : ((ERR_CYC > LOCKOUT_CYC) ? ERR_CYC : LOCKOUT_CYC);
    localparam int unsigned TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {IDLE, ENTRY, UNLOCKED, ERROR, LOCKOUT} state_t;

    state_t        state, state_n;
    logic [3:0]    sync1, sync2, prev;
    logic [3:0]    ev_c;
    logic          ev_digit_c, ev_enter_c, ev_clear_c, ev_lock_c;
    logic          digit_ok_c, full_c;
    logic [EW-1:0] entry, entry_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [FW-1:0] fail, fail_n, fail_inc_c;
    logic [TW-1:0] timer, timer_n;
    logic [EW-1:0] code_c;
    logic          code_load_c;
    logic          unlocked_q, alarm_q, locked_q;

    // Two-flop synchroniser plus previous-value flop; press = registered 1->0 edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
            prev  <= 4'hF;
        end else begin
            sync1 <= bus.key_n;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign ev_c       = prev & ~sync2;
    assign ev_clear_c = ev_c[2];
    assign ev_enter_c = ev_c[1] & ~ev_c[2];
    assign ev_lock_c  = ev_c[3] & ~ev_c[2] & ~ev_c[1];
    assign ev_digit_c = ev_c[0] & ~(|ev_c[3:1]);

    assign digit_ok_c = (32'(bus.digit_in) <= DIGIT_MAX) && (cnt < CW'(NUM_DIGITS));
    assign full_c     = (cnt == CW'(NUM_DIGITS));
    assign fail_inc_c = fail + FW'(1);

    // Next-state and datapath
    always_comb begin
        state_n     = state;
        entry_n     = entry;
        cnt_n       = cnt;
        fail_n      = fail;
        timer_n     = (timer != '0) ? timer - TW'(1) : timer;
        code_load_c = 1'b0;
        case (state)
            IDLE, ENTRY, UNLOCKED: begin
                if (ev_clear_c) begin
                    entry_n = '0;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else if (ev_enter_c) begin
                    if (full_c) begin
                        if (state == UNLOCKED) begin
`ifdef LOCK_PWD_CHANGE_EN
                            if (bus.set_mode) begin
                                code_load_c = 1'b1;
                                entry_n     = '0;
                                cnt_n       = '0;
                                timer_n     = TW'(UNLOCK_CYC - 1);
                            end
`endif
                        end else if (entry == code_c) begin
                            state_n = UNLOCKED;
                            fail_n  = '0;
                            timer_n = TW'(UNLOCK_CYC - 1);
                            entry_n = '0;
                            cnt_n   = '0;
                        end else begin
                            fail_n  = fail_inc_c;
                            entry_n = '0;
                            cnt_n   = '0;
                            if (fail_inc_c == FW'(MAX_TRIES)) begin
                                state_n = LOCKOUT;
                                timer_n = TW'(LOCKOUT_CYC - 1);
                            end else begin
                                state_n = ERROR;
                                timer_n = TW'(ERR_CYC - 1);
                            end
                        end
                    end
                end else if (ev_lock_c) begin
                    if (state == UNLOCKED) state_n = IDLE;
                end else if (ev_digit_c && digit_ok_c) begin
                    entry_n = (entry << DIGIT_W) | EW'(bus.digit_in);
                    cnt_n   = cnt + CW'(1);
                    if (state == IDLE) state_n = ENTRY;
                end
                // Auto-relock; a code change in the same cycle restarts the timer instead
                if (state == UNLOCKED && state_n == UNLOCKED && timer == '0 && !code_load_c)
                    state_n = IDLE;
            end
            ERROR: begin
                if (timer == '0) state_n = IDLE;
            end
            LOCKOUT: begin
                if (timer == '0) begin
                    state_n = IDLE;
                    fail_n  = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            entry      <= '0;
            cnt        <= '0;
            fail       <= '0;
            timer      <= '0;
            unlocked_q <= 1'b0;
            alarm_q    <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            state      <= state_n;
            entry      <= entry_n;
            cnt        <= cnt_n;
            fail       <= fail_n;
            timer      <= timer_n;
            unlocked_q <= (state_n == UNLOCKED);
            alarm_q    <= (state_n == ERROR) || (state_n == LOCKOUT);
            locked_q   <= (state_n == LOCKOUT);
        end
    end

`ifdef LOCK_PWD_CHANGE_EN
    logic [EW-1:0] code_q;
    logic          updated_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q    <= DEFAULT_CODE;
            updated_q <= 1'b0;
        end else begin
            if (code_load_c) code_q <= entry;
            updated_q <= code_load_c;
        end
    end

    assign code_c           = code_q;
    assign bus.code_updated = updated_q;
`else
    logic set_mode_unused;

    assign set_mode_unused  = bus.set_mode;
    assign code_c           = DEFAULT_CODE;
    assign bus.code_updated = 1'b0;
`endif

    assign bus.entry_digits = entry;
    assign bus.entry_cnt    = cnt;
    assign bus.fail_cnt     = fail;
    assign bus.unlocked     = unlocked_q;
    assign bus.alarm        = alarm_q;
    assign bus.locked_out   = locked_q;
endmodule

// File: tb/tb_lock_ctrl_param.sv
// Scoreboard bench for lock_ctrl_param with short timers (unlock 20, error 5, lockout 50 cycles).
// The code-change scenario is compiled only when LOCK_PWD_CHANGE_EN is defined.
module tb_lock_ctrl_param;
    localparam logic [3:0] K_DIG = 4'b0001;
    localparam logic [3:0] K_ENT = 4'b0010;
    localparam logic [3:0] K_CLR = 4'b0100;
    localparam logic [3:0] K_LCK = 4'b1000;

    typedef struct {
        string       tag;
        logic [24:0] v;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    sb_t  sb[$];
    sb_t  cur;

    lock_ctrl_param_if #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_TRIES(3)) bus ();

    lock_ctrl_param #(
        .NUM_DIGITS(4), .DIGIT_W(4), .DIGIT_MAX(9), .DEFAULT_CODE(16'h1234),
        .MAX_TRIES(3), .UNLOCK_CYC(20), .ERR_CYC(5), .LOCKOUT_CYC(50)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    // {entry_digits, entry_cnt, fail_cnt, unlocked, alarm, locked_out, code_updated}
    function automatic logic [24:0] ev(input logic [15:0] en, input logic [2:0] c, input logic [1:0] f,
                                       input logic u, input logic a, input logic l, input logic p);
        return {en, c, f, u, a, l, p};
    endfunction

    function automatic logic [24:0] status();
        return {bus.entry_digits, bus.entry_cnt, bus.fail_cnt,
                bus.unlocked, bus.alarm, bus.locked_out, bus.code_updated};
    endfunction

    function automatic void want(input string tag, input logic [24:0] v);
        sb.push_back('{tag, v});
    endfunction

    // Press keys in mask at a falling edge; returns at the falling edge after the action edge
    task automatic press(input logic [3:0] mask, input logic [3:0] d);
        bus.digit_in = d;
        bus.key_n    = ~mask;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rel();
        bus.key_n = 4'hF;
        @(negedge clk);
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) begin
            logic [15:0] c;
            c = code;
            press(K_DIG, c[i*4 +: 4]);
            rel();
        end
        press(K_ENT, 4'h0);
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.key_n    = 4'hF;
        bus.digit_in = 4'h0;
        bus.set_mode = 1'b0;
        repeat (3) @(negedge clk);
        want("reset_hold", ev(16'h0, 3'd0, 2'd0, 0, 0, 0, 0));
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        want("reset_release", ev(16'h0, 3'd0, 2'd0, 0, 0, 0, 0));
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
    endtask

    task automatic test_unlock();
        want("first_digit", ev(16'h0001, 3'd1, 2'd0, 0, 0, 0, 0));
        press(K_DIG, 4'h1);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rel();
        press(K_DIG, 4'h2); rel();
        press(K_DIG, 4'h3); rel();
        want("full_entry", ev(16'h1234, 3'd4, 2'd0, 0, 0, 0, 0));
        press(K_DIG, 4'h4);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rel();
        want("unlock", ev(16'h0, 3'd0, 2'd0, 1, 0, 0, 0));
        press(K_ENT, 4'h0);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        bus.key_n = 4'hF;
        want("unlock_last_cycle", ev(16'h0, 3'd0, 2'd0, 1, 0, 0, 0));
        repeat (19) @(negedge clk);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        want("auto_relock", ev(16'h0, 3'd0, 2'd0, 0, 0, 0, 0));
        @(negedge clk);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
    endtask

    task automatic test_short_entry();
        press(K_DIG, 4'h1); rel();
        press(K_DIG, 4'h2); rel();
        press(K_DIG, 4'h3); rel();
        want("enter_short_ignored", ev(16'h0123, 3'd3, 2'd0, 0, 0, 0, 0));
        press(K_ENT, 4'h0);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rel();
        press(K_DIG, 4'h5); rel();
        want("saturate", ev(16'h1235, 3'd4, 2'd0, 0, 0, 0, 0));
        press(K_DIG, 4'h6);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rel();
        want("clear", ev(16'h0, 3'd0, 2'd0, 0, 0, 0, 0));
        press(K_CLR, 4'h0);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rel();
    endtask

    task automatic test_lockout();
        for (int t = 1; t <= 2; t++) begin
            want("wrong_attempt", ev(16'h0, 3'd0, 2'(t), 0, 1, 0, 0));
            enter_code(16'h9999);
            cur = sb.pop_front(); n_checks++;
            if (status() !== cur.v) begin n_errors++; $display("FAIL %s %0d: got %h, expected %h", cur.tag, t, status(), cur.v); end
            bus.key_n = 4'hF;
            want("alarm_last_cycle", ev(16'h0, 3'd0, 2'(t), 0, 1, 0, 0));
            repeat (4) @(negedge clk);
            cur = sb.pop_front(); n_checks++;
            if (status() !== cur.v) begin n_errors++; $display("FAIL %s %0d: got %h, expected %h", cur.tag, t, status(), cur.v); end
            want("alarm_end", ev(16'h0, 3'd0, 2'(t), 0, 0, 0, 0));
            @(negedge clk);
            cur = sb.pop_front(); n_checks++;
            if (status() !== cur.v) begin n_errors++; $display("FAIL %s %0d: got %h, expected %h", cur.tag, t, status(), cur.v); end
        end
        want("lockout_enter", ev(16'h0, 3'd0, 2'd3, 0, 1, 1, 0));
        enter_code(16'h9999);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        want("lockout_keys_ignored", ev(16'h0, 3'd0, 2'd3, 0, 1, 1, 0));
        press(K_DIG, 4'h1);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        bus.key_n = 4'hF;
        want("lockout_last_cycle", ev(16'h0, 3'd0, 2'd3, 0, 1, 1, 0));
        repeat (46) @(negedge clk);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        want("lockout_end", ev(16'h0, 3'd0, 2'd0, 0, 0, 0, 0));
        @(negedge clk);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
    endtask

    task automatic test_priority();
        press(K_DIG, 4'h1); rel();
        want("clear_beats_digit", ev(16'h0, 3'd0, 2'd0, 0, 0, 0, 0));
        press(K_CLR | K_DIG, 4'h7);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rel();
        want("digit_over_max", ev(16'h0, 3'd0, 2'd0, 0, 0, 0, 0));
        press(K_DIG, 4'hA);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rel();
        want("digit_max", ev(16'h0009, 3'd1, 2'd0, 0, 0, 0, 0));
        press(K_DIG, 4'h9);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rel();
        want("enter_beats_digit", ev(16'h0009, 3'd1, 2'd0, 0, 0, 0, 0));
        press(K_ENT | K_DIG, 4'h2);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rel();
        press(K_CLR, 4'h0); rel();
    endtask

    task automatic test_lock_key();
        want("unlock_for_lock", ev(16'h0, 3'd0, 2'd0, 1, 0, 0, 0));
        enter_code(16'h1234);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        bus.key_n = 4'hF;
        repeat (2) @(negedge clk);
        want("lock_key", ev(16'h0, 3'd0, 2'd0, 0, 0, 0, 0));
        press(K_LCK, 4'h0);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rel();
    endtask

    task automatic test_async_reset();
        enter_code(16'h9999);
        bus.key_n = 4'hF;
        repeat (6) @(negedge clk);
        press(K_DIG, 4'h1); rel();
        want("entry_before_reset", ev(16'h0012, 3'd2, 2'd1, 0, 0, 0, 0));
        press(K_DIG, 4'h2);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        bus.key_n = 4'hF;
        want("async_reset", ev(16'h0, 3'd0, 2'd0, 0, 0, 0, 0));
        rst = 1'b0;
        #1;
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

`ifdef LOCK_PWD_CHANGE_EN
    task automatic test_code_change();
        enter_code(16'h1234);
        bus.set_mode = 1'b1;
        press(K_DIG, 4'h5); rel();
        press(K_DIG, 4'h6); rel();
        press(K_DIG, 4'h7); rel();
        want("new_code_entry", ev(16'h5678, 3'd4, 2'd0, 1, 0, 0, 0));
        press(K_DIG, 4'h8);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        want("code_updated_pulse", ev(16'h0, 3'd0, 2'd0, 1, 0, 0, 1));
        press(K_ENT, 4'h0);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        want("code_updated_one_cycle", ev(16'h0, 3'd0, 2'd0, 1, 0, 0, 0));
        rel();
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        bus.set_mode = 1'b0;
        press(K_LCK, 4'h0); rel();
        want("old_code_fails", ev(16'h0, 3'd0, 2'd1, 0, 1, 0, 0));
        enter_code(16'h1234);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        bus.key_n = 4'hF;
        repeat (6) @(negedge clk);
        want("new_code_unlocks", ev(16'h0, 3'd0, 2'd0, 1, 0, 0, 0));
        enter_code(16'h5678);
        cur = sb.pop_front(); n_checks++;
        if (status() !== cur.v) begin n_errors++; $display("FAIL %s: got %h, expected %h", cur.tag, status(), cur.v); end
        rel();
    endtask
`endif

    initial begin
        rst          = 1'b0;
        bus.key_n    = 4'hF;
        bus.digit_in = 4'h0;
        bus.set_mode = 1'b0;
        @(negedge clk);
        test_reset();
        test_unlock();
        test_short_entry();
        test_lockout();
        test_priority();
        test_lock_key();
        test_async_reset();
`ifdef LOCK_PWD_CHANGE_EN
        test_code_change();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
